// File: rtl/mc_pkg.sv
// mc_pkg: shared state encoding, instruction field constants and ALU codes for the multicycle controller.
package mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_OR   = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_SUB  = 3'd6;
  localparam logic [2:0] ALU_SLT  = 3'd7;
  // An unrecognised opcode maps to S_FETCH, which doubles as the illegal-opcode indication.
  function automatic state_t decode_next(input logic [5:0] op);
    return op == OP_RTYPE                 ? S_EXEC   :
           (op == OP_LW || op == OP_SW)   ? S_MEMADR :
           op == OP_BEQ                   ? S_BRANCH :
           op == OP_J                     ? S_JUMP   :
           (op == OP_ADDI || op == OP_SLTI ||
            op == OP_ANDI || op == OP_ORI) ? S_IEXEC  : S_FETCH;
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational map from controller state and instruction fields to the ALU control code.
module alu_decoder
  import mc_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  state_t                  state,
  input  logic [5:0]              opcode,
  input  logic [5:0]              funct,
  output logic [ALU_CTRL_W-1:0]   alu_control,
  output logic                    bad_funct
);
  logic [2:0] fn_code;
  logic [2:0] op_code;
  logic [2:0] code;
  logic       fn_ok;
  assign fn_ok   = funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                   funct == FN_OR  || funct == FN_SLT;
  assign fn_code = funct == FN_ADD ? ALU_ADD :
                   funct == FN_SUB ? ALU_SUB :
                   funct == FN_AND ? ALU_AND :
                   funct == FN_OR  ? ALU_OR  :
                   funct == FN_SLT ? ALU_SLT : 3'd0;
  assign op_code = opcode == OP_SLTI ? ALU_SLT :
                   opcode == OP_ANDI ? ALU_AND :
                   opcode == OP_ORI  ? ALU_OR  : ALU_ADD;
  assign code    = state == S_EXEC   ? fn_code :
                   state == S_IEXEC  ? op_code :
                   state == S_BRANCH ? ALU_SUB :
                   (state == S_FETCH || state == S_DECODE || state == S_MEMADR) ? ALU_ADD : 3'd0;
  assign alu_control = ALU_CTRL_W'(code);
  assign bad_funct   = state == S_EXEC && !fn_ok;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle MIPS-style datapath with optional memory handshake.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter int MEM_WAIT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  pc_write_cond,
  output logic                  iord,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  mem_to_reg,
  output logic                  reg_dst,
  output logic                  reg_write,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            pc_source,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [3:0]            state_o,
  output logic                  illegal
);
  if (ALU_CTRL_W < 3) begin : g_bad_width
    $error("multicycle_control: ALU_CTRL_W must be at least 3");
  end
  state_t                  state;
  logic                    run;
  logic                    mem_done;
  logic                    fetch_done;
  logic                    bad_funct;
  logic [ALU_CTRL_W-1:0]   alu_code;
  alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_decoder (
    .state       (state),
    .opcode      (opcode),
    .funct       (funct),
    .alu_control (alu_code),
    .bad_funct   (bad_funct)
  );
  assign mem_done   = MEM_WAIT == 0 || mem_ready;
  assign fetch_done = state == S_FETCH && mem_done;
  // run stays low through reset and the cycle after release, so FETCH starts on the first edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      run   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run)
        case (state)
          S_FETCH:  state <= mem_done ? S_DECODE : S_FETCH;
          S_DECODE: state <= decode_next(opcode);
          S_MEMADR: state <= opcode == OP_LW ? S_MEMRD : S_MEMWR;
          S_MEMRD:  state <= mem_done ? S_MEMWB : S_MEMRD;
          S_MEMWR:  state <= mem_done ? S_FETCH : S_MEMWR;
          S_EXEC:   state <= bad_funct ? S_FETCH : S_ALUWB;
          S_IEXEC:  state <= S_IWB;
          default:  state <= S_FETCH;
        endcase
    end
  end
  assign state_o       = state;
  assign mem_read      = run && (state == S_FETCH || state == S_MEMRD);
  assign mem_write     = run && state == S_MEMWR;
  assign iord          = run && (state == S_MEMRD || state == S_MEMWR);
  assign ir_write      = run && fetch_done;
  assign pc_write      = run && (fetch_done || state == S_JUMP);
  assign pc_write_cond = run && state == S_BRANCH;
  assign mem_to_reg    = run && state == S_MEMWB;
  assign reg_dst       = run && state == S_ALUWB;
  assign reg_write     = run && (state == S_MEMWB || state == S_ALUWB || state == S_IWB);
  assign alu_src_a     = run && (state == S_MEMADR || state == S_EXEC ||
                                 state == S_BRANCH || state == S_IEXEC);
  assign alu_src_b     = !run                                     ? 2'b00 :
                         state == S_FETCH                         ? 2'b01 :
                         state == S_DECODE                        ? 2'b11 :
                         (state == S_MEMADR || state == S_IEXEC)  ? 2'b10 : 2'b00;
  assign pc_source     = !run                ? 2'b00 :
                         state == S_BRANCH   ? 2'b01 :
                         state == S_JUMP     ? 2'b10 : 2'b00;
  assign alu_control   = run ? alu_code : '0;
  assign illegal       = run && ((state == S_DECODE && decode_next(opcode) == S_FETCH) || bad_funct);
endmodule
